// File: rtl/ecc_final_top.sv
// Elliptic-curve scalar multiply Q = d*G with a signature-style pair (r, s).
// A single bit-serial modular multiplier is shared by point arithmetic, inversion and signing.
module ecc_final_top #(
  parameter int unsigned  W  = 256,
  parameter logic [W-1:0] P  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
  parameter logic [W-1:0] A  = '0,
  parameter logic [W-1:0] B  = W'(7),
  parameter logic [W-1:0] GX = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798,
  parameter logic [W-1:0] GY = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8,
  parameter logic [W-1:0] N  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [95:0]  message,
  input  logic [255:0] priv_key,
  output logic         Done,
  output logic         invalid_error
);

  localparam int unsigned MW = 96;
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned CW = $clog2((W > MW) ? W : MW);
  localparam logic [W-1:0] A_RED = A % P;
  localparam logic [W-1:0] PM2   = P - W'(2);

  typedef enum logic [4:0] {
    S_IDLE, S_CHECK, S_DBL_GO, S_DBL_NUM, S_POST, S_ADD_GO, S_NEXT,
    S_INV_SQ, S_INV_SQ_D, S_INV_MUL_D, S_INV_STEP, S_LAM_D, S_X3, S_Y3,
    S_SIGN0, S_MRED, S_SIGN1, S_SIGN2, S_MWAIT, S_FINISH
  } state_e;

  state_e          state_q, state_d, ret_q, ret_d;
  logic [W-1:0]    key_q, key_d;
  logic [MW-1:0]   msg_q, msg_d;
  logic [W-1:0]    rx_q, rx_d, ry_q, ry_d;
  logic            rinf_q, rinf_d, phase_q, phase_d;
  logic [IW-1:0]   bit_q, bit_d, eidx_q, eidx_d;
  logic [W-1:0]    num_q, num_d, den_q, den_d, x2_q, x2_d;
  logic [W-1:0]    zinv_q, zinv_d, lam_q, lam_d, x3_q, x3_d, em_q, em_d;
  logic [W-1:0]    ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            modn_q, modn_d;
  logic [W-1:0]    qx, qx_d, qy, qy_d, sig_r, sig_r_d, sig_s, sig_s_d;
  logic            q_inf, q_inf_d;
  logic            done_q, done_d, err_q, err_d;
  logic [W-1:0]    x3_c;

  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return W'(s);
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [W:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + {1'b0, m} - {1'b0, b};
    return W'(t);
  endfunction

  // One interleaved step: (2*acc + add) mod m with acc, add < m, so the sum stays below 3m.
  function automatic logic [W-1:0] mstep(input logic [W-1:0] acc, input logic [W-1:0] add,
                                         input logic [W-1:0] m);
    logic [W+1:0] t;
    logic [W+1:0] mm;
    mm = {2'b00, m};
    t  = {1'b0, acc, 1'b0} + {2'b00, add};
    if (t >= mm) t = t - mm;
    if (t >= mm) t = t - mm;
    return W'(t);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;  ret_q  <= S_IDLE;
      key_q   <= '0;      msg_q  <= '0;
      rx_q    <= '0;      ry_q   <= '0;
      rinf_q  <= 1'b0;    phase_q <= 1'b0;
      bit_q   <= '0;      eidx_q <= '0;
      num_q   <= '0;      den_q  <= '0;   x2_q  <= '0;
      zinv_q  <= '0;      lam_q  <= '0;   x3_q  <= '0;  em_q <= '0;
      ma_q    <= '0;      mb_q   <= '0;   acc_q <= '0;
      cnt_q   <= '0;      modn_q <= 1'b0;
      qx      <= '0;      qy     <= '0;   q_inf <= 1'b0;
      sig_r   <= '0;      sig_s  <= '0;
      done_q  <= 1'b0;    err_q  <= 1'b0;
    end else begin
      state_q <= state_d; ret_q  <= ret_d;
      key_q   <= key_d;   msg_q  <= msg_d;
      rx_q    <= rx_d;    ry_q   <= ry_d;
      rinf_q  <= rinf_d;  phase_q <= phase_d;
      bit_q   <= bit_d;   eidx_q <= eidx_d;
      num_q   <= num_d;   den_q  <= den_d;  x2_q  <= x2_d;
      zinv_q  <= zinv_d;  lam_q  <= lam_d;  x3_q  <= x3_d;  em_q <= em_d;
      ma_q    <= ma_d;    mb_q   <= mb_d;   acc_q <= acc_d;
      cnt_q   <= cnt_d;   modn_q <= modn_d;
      qx      <= qx_d;    qy     <= qy_d;   q_inf <= q_inf_d;
      sig_r   <= sig_r_d; sig_s  <= sig_s_d;
      done_q  <= done_d;  err_q  <= err_d;
    end
  end

  // Sequencer: each multiply launches into S_MWAIT and resumes at ret_q with the product in acc_q.
  always_comb begin
    state_d = state_q;  ret_d  = ret_q;
    key_d   = key_q;    msg_d  = msg_q;
    rx_d    = rx_q;     ry_d   = ry_q;
    rinf_d  = rinf_q;   phase_d = phase_q;
    bit_d   = bit_q;    eidx_d = eidx_q;
    num_d   = num_q;    den_d  = den_q;  x2_d  = x2_q;
    zinv_d  = zinv_q;   lam_d  = lam_q;  x3_d  = x3_q;  em_d = em_q;
    ma_d    = ma_q;     mb_d   = mb_q;   acc_d = acc_q;
    cnt_d   = cnt_q;    modn_d = modn_q;
    qx_d    = qx;       qy_d   = qy;     q_inf_d = q_inf;
    sig_r_d = sig_r;    sig_s_d = sig_s;
    done_d  = done_q;   err_d  = err_q;
    x3_c    = '0;

    case (state_q)
      S_IDLE: begin
        key_d   = priv_key[W-1:0];
        msg_d   = message;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (key_q == '0 || key_q >= N) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          rinf_d  = 1'b1;
          rx_d    = '0;
          ry_d    = '0;
          bit_d   = IW'(W - 1);
          phase_d = 1'b0;
          state_d = S_DBL_GO;
        end
      end
      S_DBL_GO: begin
        if (rinf_q || ry_q == '0) begin
          rinf_d  = 1'b1;
          state_d = S_POST;
        end else begin
          x2_d = rx_q;
          ma_d = rx_q;  mb_d = rx_q;  acc_d = '0;  cnt_d = CW'(W - 1);
          modn_d = 1'b0;  ret_d = S_DBL_NUM;  state_d = S_MWAIT;
        end
      end
      S_DBL_NUM: begin
        num_d   = add_mod(add_mod(add_mod(acc_q, acc_q, P), acc_q, P), A_RED, P);
        den_d   = add_mod(ry_q, ry_q, P);
        zinv_d  = W'(1);
        eidx_d  = IW'(W - 1);
        state_d = S_INV_SQ;
      end
      S_POST: begin
        if (!phase_q && key_q[bit_q]) begin
          phase_d = 1'b1;
          state_d = S_ADD_GO;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_ADD_GO: begin
        if (rinf_q) begin
          rx_d = GX;  ry_d = GY;  rinf_d = 1'b0;
          state_d = S_NEXT;
        end else if (rx_q == GX) begin
          // Equal x: same point doubles, opposite point cancels to infinity.
          if (ry_q == GY) begin
            state_d = S_DBL_GO;
          end else begin
            rinf_d  = 1'b1;
            state_d = S_NEXT;
          end
        end else begin
          num_d   = sub_mod(GY, ry_q, P);
          den_d   = sub_mod(GX, rx_q, P);
          x2_d    = GX;
          zinv_d  = W'(1);
          eidx_d  = IW'(W - 1);
          state_d = S_INV_SQ;
        end
      end
      S_NEXT: begin
        if (bit_q == '0) begin
          state_d = S_SIGN0;
        end else begin
          bit_d   = bit_q - IW'(1);
          phase_d = 1'b0;
          state_d = S_DBL_GO;
        end
      end
      S_INV_SQ: begin
        ma_d = zinv_q;  mb_d = zinv_q;  acc_d = '0;  cnt_d = CW'(W - 1);
        modn_d = 1'b0;  ret_d = S_INV_SQ_D;  state_d = S_MWAIT;
      end
      S_INV_SQ_D: begin
        zinv_d = acc_q;
        if (PM2[eidx_q]) begin
          ma_d = acc_q;  mb_d = den_q;  acc_d = '0;  cnt_d = CW'(W - 1);
          modn_d = 1'b0;  ret_d = S_INV_MUL_D;  state_d = S_MWAIT;
        end else begin
          state_d = S_INV_STEP;
        end
      end
      S_INV_MUL_D: begin
        zinv_d  = acc_q;
        state_d = S_INV_STEP;
      end
      S_INV_STEP: begin
        if (eidx_q == '0) begin
          ma_d = num_q;  mb_d = zinv_q;  acc_d = '0;  cnt_d = CW'(W - 1);
          modn_d = 1'b0;  ret_d = S_LAM_D;  state_d = S_MWAIT;
        end else begin
          eidx_d  = eidx_q - IW'(1);
          state_d = S_INV_SQ;
        end
      end
      S_LAM_D: begin
        lam_d = acc_q;
        ma_d = acc_q;  mb_d = acc_q;  acc_d = '0;  cnt_d = CW'(W - 1);
        modn_d = 1'b0;  ret_d = S_X3;  state_d = S_MWAIT;
      end
      S_X3: begin
        x3_c = sub_mod(sub_mod(acc_q, rx_q, P), x2_q, P);
        x3_d = x3_c;
        ma_d = lam_q;  mb_d = sub_mod(rx_q, x3_c, P);  acc_d = '0;  cnt_d = CW'(W - 1);
        modn_d = 1'b0;  ret_d = S_Y3;  state_d = S_MWAIT;
      end
      S_Y3: begin
        ry_d    = sub_mod(acc_q, ry_q, P);
        rx_d    = x3_q;
        rinf_d  = 1'b0;
        state_d = S_POST;
      end
      S_SIGN0: begin
        qx_d    = rx_q;
        qy_d    = ry_q;
        q_inf_d = rinf_q;
        if (rinf_q) begin
          sig_r_d = '0;
          sig_s_d = '0;
          done_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_FINISH;
        end else begin
          sig_r_d = (rx_q >= N) ? rx_q - N : rx_q;
          acc_d   = '0;
          cnt_d   = CW'(MW - 1);
          state_d = S_MRED;
        end
      end
      S_MRED: begin
        acc_d = mstep(acc_q, W'(msg_q[MW-1]), N);
        msg_d = msg_q << 1;
        if (cnt_q == '0) state_d = S_SIGN1;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_SIGN1: begin
        em_d = acc_q;
        ma_d = sig_r;  mb_d = key_q;  acc_d = '0;  cnt_d = CW'(W - 1);
        modn_d = 1'b1;  ret_d = S_SIGN2;  state_d = S_MWAIT;
      end
      S_SIGN2: begin
        sig_s_d = add_mod(em_q, acc_q, N);
        done_d  = 1'b1;
        err_d   = 1'b0;
        state_d = S_FINISH;
      end
      S_MWAIT: begin
        acc_d = mstep(acc_q, mb_q[W-1] ? ma_q : '0, modn_q ? N : P);
        mb_d  = mb_q << 1;
        if (cnt_q == '0) state_d = ret_q;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FINISH: state_d = S_FINISH;
      default:  state_d = S_IDLE;
    endcase
  end

  assign Done          = done_q;
  assign invalid_error = err_q;

  // Result registers are observed hierarchically; B is descriptive only.
  logic unused_c;
  assign unused_c = ^{B, qx, qy, q_inf, sig_s};

  if (W < 256) begin : g_key_hi
    logic unused_key_c;
    assign unused_key_c = ^priv_key[255:W];
  end

endmodule

// File: tb/tb_ecc_final_top.sv
// Checks a toy-curve instance against a repeated-addition point model and a secp256k1 instance on d=1.
module tb_ecc_final_top;

  localparam int TP = 17, TA = 2, TGX = 5, TGY = 1, TN = 19;
  localparam logic [255:0] BGX = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] BGY = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
  localparam logic [255:0] BN  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_t, rst_b, done_t, err_t, done_b, err_b;
  logic [95:0]  msg_t, msg_b;
  logic [255:0] key_t, key_b;
  int n_checks, n_pass;

  ecc_final_top #(.W(8), .P(8'd17), .A(8'd2), .B(8'd2), .GX(8'd5), .GY(8'd1), .N(8'd19)) u_toy (
    .clk(clk), .reset(rst_t), .message(msg_t), .priv_key(key_t),
    .Done(done_t), .invalid_error(err_t));

  ecc_final_top u_big (
    .clk(clk), .reset(rst_b), .message(msg_b), .priv_key(key_b),
    .Done(done_b), .invalid_error(err_b));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int inv_mod(input int a);
    for (int x = 1; x < TP; x++) if ((a * x) % TP == 1) return x;
    return 0;
  endfunction

  task automatic pt_add(input int x1, input int y1, input bit i1, input int x2, input int y2,
                        input bit i2, output int x3, output int y3, output bit i3);
    int lam;
    if (i1) begin x3 = x2; y3 = y2; i3 = i2; end
    else if (i2) begin x3 = x1; y3 = y1; i3 = 1'b0; end
    else if (x1 == x2 && (y1 + y2) % TP == 0) begin x3 = 0; y3 = 0; i3 = 1'b1; end
    else begin
      if (x1 == x2) lam = ((3 * x1 * x1 + TA) % TP) * inv_mod((2 * y1) % TP) % TP;
      else          lam = ((y2 - y1 + TP) % TP) * inv_mod((x2 - x1 + TP) % TP) % TP;
      x3 = (lam * lam + 2 * TP - x1 - x2) % TP;
      y3 = (lam * ((x1 - x3 + TP) % TP) + TP - y1) % TP;
      i3 = 1'b0;
    end
  endtask

  task automatic model_toy(input int d, input logic [95:0] e, output int qx, output int qy,
                           output int r, output int s);
    int x, y;
    bit inf;
    x = 0; y = 0; inf = 1'b1;
    repeat (d) pt_add(x, y, inf, TGX, TGY, 1'b0, x, y, inf);
    qx = x; qy = y;
    r = x % TN;
    s = (int'(e % 96'd19) + r * d) % TN;
  endtask

  task automatic run_toy(input logic [255:0] key, input logic [95:0] e);
    int cyc;
    rst_t = 1'b0; key_t = key; msg_t = e;
    repeat (2) @(negedge clk);
    rst_t = 1'b1;
    @(negedge clk);
    key_t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    msg_t = {$urandom, $urandom, $urandom};
    cyc = 1;
    while (!done_t && cyc < 10000) begin @(negedge clk); cyc++; end
  endtask

  task automatic check_toy(input string tag, input logic [255:0] key, input logic [95:0] e,
                           input bit ex_err, input int ex_qx, input int ex_qy,
                           input int ex_r, input int ex_s);
    run_toy(key, e);
    check({tag, "_done"}, 256'(done_t), 256'd1);
    check({tag, "_err"},  256'(err_t),  256'(ex_err));
    check({tag, "_qx"},   256'(u_toy.qx),    256'(ex_qx));
    check({tag, "_qy"},   256'(u_toy.qy),    256'(ex_qy));
    check({tag, "_r"},    256'(u_toy.sig_r), 256'(ex_r));
    check({tag, "_s"},    256'(u_toy.sig_s), 256'(ex_s));
  endtask

  task automatic check_big(input string tag, input logic [255:0] key, input logic [95:0] e,
                           input bit ex_err, input logic [255:0] ex_qx, input logic [255:0] ex_qy,
                           input logic [255:0] ex_r, input logic [255:0] ex_s);
    int cyc;
    rst_b = 1'b0; key_b = key; msg_b = e;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    key_b = '1; msg_b = '1;
    cyc = 1;
    while (!done_b && cyc < 20000) begin @(negedge clk); cyc++; end
    check({tag, "_done"}, 256'(done_b), 256'd1);
    check({tag, "_err"},  256'(err_b),  256'(ex_err));
    check({tag, "_qx"},   u_big.qx,    ex_qx);
    check({tag, "_qy"},   u_big.qy,    ex_qy);
    check({tag, "_r"},    u_big.sig_r, ex_r);
    check({tag, "_s"},    u_big.sig_s, ex_s);
  endtask

  int dk [6] = '{5, 1, 2, 3, 18, 4};
  int ex [6] = '{9, 5, 6, 10, 5, 3};
  int ey [6] = '{16, 1, 3, 6, 16, 1};
  int es [6] = '{5, 5, 12, 11, 14, 12};

  initial begin
    int mqx, mqy, mr, ms, d;
    logic [95:0]  e;
    logic [255:0] k;
    logic [256:0] t;
    n_checks = 0; n_pass = 0;
    rst_t = 1'b0; rst_b = 1'b0;
    key_t = '0; key_b = '0; msg_t = '0; msg_b = '0;
    repeat (3) @(negedge clk);
    check("rst_done",  256'(done_t), 256'd0);
    check("rst_err",   256'(err_t),  256'd0);
    check("rst_qx",    256'(u_toy.qx), 256'd0);
    check("rst_sig_s", 256'(u_toy.sig_s), 256'd0);
    check("rst_big_done", 256'(done_b), 256'd0);
    check("rst_big_r",    u_big.sig_r, 256'd0);

    for (int i = 0; i < 6; i++)
      check_toy($sformatf("dir%0d", i), 256'(dk[i]), (i == 0) ? 96'd616263 : 96'd0,
                1'b0, ex[i], ey[i], ex[i], es[i]);

    #2 rst_t = 1'b0;
    #1;
    check("async_done",  256'(done_t), 256'd0);
    check("async_sig_r", 256'(u_toy.sig_r), 256'd0);
    check("async_qx",    256'(u_toy.qx), 256'd0);
    @(negedge clk);

    check_toy("inv0",  256'd0,  96'd77, 1'b1, 0, 0, 0, 0);
    check_toy("inv19", 256'd19, 96'd77, 1'b1, 0, 0, 0, 0);
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    k[7:0] = 8'd0;
    check_toy("inv_lowzero", k, 96'd3, 1'b1, 0, 0, 0, 0);
    k[7:0] = 8'(19 + $urandom_range(0, 236));
    check_toy("inv_rand", k, 96'd3, 1'b1, 0, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(1, 18);
      e = {$urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      k[7:0] = 8'(d);
      model_toy(d, e, mqx, mqy, mr, ms);
      check_toy($sformatf("rnd%0d_d%0d", i, d), k, e, 1'b0, mqx, mqy, mr, ms);
    end

    rst_t = 1'b0; key_t = 256'd18; msg_t = 96'd5;
    repeat (2) @(negedge clk);
    rst_t = 1'b1;
    repeat (150) @(negedge clk);
    check("mid_busy", 256'(done_t), 256'd0);
    #2 rst_t = 1'b0;
    #1;
    check("mid_rst_done", 256'(done_t), 256'd0);
    @(negedge clk);
    check_toy("rerun_d4", 256'd4, 96'd0, 1'b0, 3, 1, 3, 12);

    e = {$urandom, $urandom, $urandom};
    t = 257'(e) + 257'(BGX);
    t = t % {1'b0, BN};
    check_big("big_d1", 256'd1, e, 1'b0, BGX, BGY, BGX, t[255:0]);
    check_big("big_dN", BN, e, 1'b1, '0, '0, '0, '0);
    check_big("big_ones", '1, e, 1'b1, '0, '0, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
